// File: rtl/unary_acc_nch.sv
// N-lane unary accumulator: counts ones across all lanes into a saturating counter,
// then replays the total as a single thermometer-coded stream on dout.
module unary_acc_nch #(
    parameter int NCH     = 2,
    parameter int CNT_W   = 5,
    parameter int MAX_CNT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             read_or_write,
    input  logic [NCH-1:0]   din,
    output logic             dout,
    output logic             C,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam int POP_W = $clog2(NCH + 1);
    localparam int SUM_W = CNT_W + POP_W + 1;

    typedef enum logic [1:0] {ST_ACC, ST_EMIT, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             dout_q, dout_d;
    logic             c_q, c_d;
    logic             done_q, done_d;
    logic [POP_W-1:0] pop;
    logic [CNT_W:0]   acc_sat;

    function automatic logic [POP_W-1:0] popcount(input logic [NCH-1:0] v);
        logic [POP_W-1:0] p;
        p = '0;
        for (int i = 0; i < NCH; i++) begin
            p = p + POP_W'(v[i]);
        end
        return p;
    endfunction

    // Returns {clipped, value}; the sum is formed wide enough that nothing wraps before the compare.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic [POP_W-1:0] b);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(a) + SUM_W'(b);
        if (sum > SUM_W'(MAX_CNT)) begin
            return {1'b1, CNT_W'(MAX_CNT)};
        end
        return {1'b0, sum[CNT_W-1:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            cnt_q   <= '0;
            rem_q   <= '0;
            dout_q  <= 1'b0;
            c_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                ST_ACC:  if (read_or_write) state_d = ST_EMIT;
                ST_EMIT: begin
                    if (!read_or_write)      state_d = ST_ACC;
                    else if (rem_q == '0)    state_d = ST_DONE;
                end
                ST_DONE: if (!read_or_write) state_d = ST_ACC;
                default: state_d = ST_ACC;
            endcase
        end
    end

    // dout and done default low so they only assert for the cycle that calls for them.
    always_comb begin
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        c_d     = c_q;
        dout_d  = 1'b0;
        done_d  = 1'b0;
        pop     = popcount(din);
        acc_sat = sat_add(cnt_q, pop);
        if (en) begin
            case (state_q)
                ST_ACC: begin
                    if (read_or_write) begin
                        rem_d = cnt_q;
                    end else begin
                        cnt_d = acc_sat[CNT_W-1:0];
                        c_d   = c_q | acc_sat[CNT_W];
                    end
                end
                ST_EMIT: begin
                    if (!read_or_write) begin
                        cnt_d = '0;
                        c_d   = 1'b0;
                        rem_d = '0;
                    end else if (rem_q != '0) begin
                        dout_d = 1'b1;
                        rem_d  = rem_q - CNT_W'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!read_or_write) begin
                        cnt_d = '0;
                        c_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = dout_q;
    assign C    = c_q;
    assign done = done_q;
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_unary_acc_nch.sv
// Bench for unary_acc_nch: a default instance (MAX 31) and a wide instance (MAX 63) share
// stimulus and are checked against a running-total model of ones seen.
module tb_unary_acc_nch;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       rw  = 1'b0;
    logic [1:0] din = 2'b00;

    logic       dout_a, c_a, done_a;
    logic [4:0] cnt_a;
    logic       dout_b, c_b, done_b;
    logic [5:0] cnt_b;

    int checks = 0;
    int errors = 0;
    int total  = 0;

    always #5 clk = ~clk;

    unary_acc_nch u_dut (
        .clk(clk), .rst(rst), .en(en), .read_or_write(rw), .din(din),
        .dout(dout_a), .C(c_a), .done(done_a), .cnt(cnt_a)
    );

    unary_acc_nch #(.NCH(2), .CNT_W(6), .MAX_CNT(63)) u_leg (
        .clk(clk), .rst(rst), .en(en), .read_or_write(rw), .din(din),
        .dout(dout_b), .C(c_b), .done(done_b), .cnt(cnt_b)
    );

    function automatic int sat(int t, int m);
        return (t > m) ? m : t;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b1; rw = 1'b1; din = 2'b11;
        step;
        rst = 1'b0; rw = 1'b0; din = 2'b00;
        total = 0;
    endtask

    task automatic accumulate(int n, logic [1:0] pat, bit rnd);
        for (int i = 0; i < n; i++) begin
            en  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            rw  = en ? 1'b0 : 1'($urandom_range(0, 1));
            din = rnd ? 2'($urandom) : pat;
            step;
            if (en) total += $countones(din);
            checks++;
            if ({cnt_a, c_a, dout_a, done_a} !== {5'(sat(total, 31)), total > 31, 2'b00}) begin
                errors++;
                $display("FAIL acc_a t=%0t got cnt=%0d C=%b dout=%b done=%b want cnt=%0d C=%b",
                         $time, cnt_a, c_a, dout_a, done_a, sat(total, 31), total > 31);
            end
            checks++;
            if ({cnt_b, c_b, dout_b, done_b} !== {6'(sat(total, 63)), total > 63, 2'b00}) begin
                errors++;
                $display("FAIL acc_b t=%0t got cnt=%0d C=%b dout=%b done=%b want cnt=%0d C=%b",
                         $time, cnt_b, c_b, dout_b, done_b, sat(total, 63), total > 63);
            end
        end
    endtask

    // Emit phase; en is dropped for frz_len cycles once frz_at ones have been requested.
    task automatic emit(int frz_at, int frz_len);
        int na, nb, act, frozen;
        bit da, ka, db, kb;
        na = sat(total, 31); nb = sat(total, 63); act = 0; frozen = 0;
        en = 1'b1; rw = 1'b1; din = 2'($urandom);
        step;
        checks++;
        if ({dout_a, done_a, cnt_a, c_a} !== {2'b00, 5'(na), total > 31}) begin
            errors++;
            $display("FAIL emit_entry_a t=%0t got dout=%b done=%b cnt=%0d want 0 0 %0d",
                     $time, dout_a, done_a, cnt_a, na);
        end
        checks++;
        if ({dout_b, done_b, cnt_b, c_b} !== {2'b00, 6'(nb), total > 63}) begin
            errors++;
            $display("FAIL emit_entry_b t=%0t got dout=%b done=%b cnt=%0d want 0 0 %0d",
                     $time, dout_b, done_b, cnt_b, nb);
        end
        while (act < nb + 3) begin
            if (act == frz_at && frozen < frz_len) begin
                en = 1'b0; frozen++;
            end else begin
                en = 1'b1;
            end
            rw = 1'b1; din = 2'($urandom);
            step;
            if (en) act++;
            da = en && (act <= na); ka = en && (act == na + 1);
            db = en && (act <= nb); kb = en && (act == nb + 1);
            checks++;
            if ({dout_a, done_a, cnt_a, c_a} !== {da, ka, 5'(na), total > 31}) begin
                errors++;
                $display("FAIL emit_a t=%0t act=%0d en=%b got dout=%b done=%b cnt=%0d C=%b want dout=%b done=%b cnt=%0d",
                         $time, act, en, dout_a, done_a, cnt_a, c_a, da, ka, na);
            end
            checks++;
            if ({dout_b, done_b, cnt_b, c_b} !== {db, kb, 6'(nb), total > 63}) begin
                errors++;
                $display("FAIL emit_b t=%0t act=%0d en=%b got dout=%b done=%b cnt=%0d C=%b want dout=%b done=%b cnt=%0d",
                         $time, act, en, dout_b, done_b, cnt_b, c_b, db, kb, nb);
            end
        end
        en = 1'b1;
    endtask

    task automatic restart;
        en = 1'b1; rw = 1'b0; din = 2'($urandom);
        step;
        total = 0;
        checks++;
        if ({cnt_a, c_a, dout_a, done_a} !== 8'h00 || {cnt_b, c_b, dout_b, done_b} !== 9'h000) begin
            errors++;
            $display("FAIL restart t=%0t got a=%0d/%b/%b/%b b=%0d/%b/%b/%b want all 0",
                     $time, cnt_a, c_a, dout_a, done_a, cnt_b, c_b, dout_b, done_b);
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({cnt_a, c_a, dout_a, done_a} !== 8'h00 || {cnt_b, c_b, dout_b, done_b} !== 9'h000) begin
            errors++;
            $display("FAIL reset_state got a=%0d/%b/%b/%b b=%0d/%b/%b/%b want all 0",
                     cnt_a, c_a, dout_a, done_a, cnt_b, c_b, dout_b, done_b);
        end
        accumulate(5, 2'b11, 1'b0);
        rst = 1'b1;
        #3;
        checks++;
        if (cnt_a !== 5'd10 || cnt_b !== 6'd10) begin
            errors++;
            $display("FAIL reset_async got cnt_a=%0d cnt_b=%0d want 10 10 before edge", cnt_a, cnt_b);
        end
        step;
        rst = 1'b0;
        total = 0;
        checks++;
        if ({cnt_a, c_a, dout_a, done_a} !== 8'h00 || {cnt_b, c_b, dout_b, done_b} !== 9'h000) begin
            errors++;
            $display("FAIL reset_acc got a=%0d/%b/%b/%b b=%0d/%b/%b/%b want all 0",
                     cnt_a, c_a, dout_a, done_a, cnt_b, c_b, dout_b, done_b);
        end
    endtask

    task automatic test_legacy_saturation;
        do_reset;
        accumulate(19, 2'b11, 1'b0);
        emit(1000, 0);
        restart;
    endtask

    task automatic test_zero_count;
        do_reset;
        emit(1000, 0);
        restart;
    endtask

    task automatic test_freeze;
        do_reset;
        accumulate(5, 2'b11, 1'b0);
        emit(4, 3);
        restart;
    endtask

    task automatic test_abort;
        do_reset;
        accumulate(10, 2'b11, 1'b0);
        en = 1'b1; rw = 1'b1; din = 2'b00;
        step;
        for (int i = 0; i < 5; i++) begin
            step;
            checks++;
            if ({dout_a, done_a, dout_b, done_b} !== 4'b1010) begin
                errors++;
                $display("FAIL abort_emit i=%0d got dout_a=%b done_a=%b dout_b=%b done_b=%b want 1 0 1 0",
                         i, dout_a, done_a, dout_b, done_b);
            end
        end
        rw = 1'b0; din = 2'b11;
        step;
        total = 0;
        checks++;
        if ({cnt_a, c_a, dout_a, done_a} !== 8'h00 || {cnt_b, c_b, dout_b, done_b} !== 9'h000) begin
            errors++;
            $display("FAIL abort got a=%0d/%b/%b/%b b=%0d/%b/%b/%b want all 0",
                     cnt_a, c_a, dout_a, done_a, cnt_b, c_b, dout_b, done_b);
        end
        accumulate(3, 2'b01, 1'b0);
        emit(1000, 0);
        restart;
    endtask

    task automatic test_reset_emit;
        do_reset;
        accumulate(4, 2'b11, 1'b0);
        en = 1'b1; rw = 1'b1;
        for (int i = 0; i < 4; i++) step;
        rst = 1'b1;
        step;
        rst = 1'b0; rw = 1'b0; din = 2'b00;
        total = 0;
        checks++;
        if ({cnt_a, c_a, dout_a, done_a} !== 8'h00 || {cnt_b, c_b, dout_b, done_b} !== 9'h000) begin
            errors++;
            $display("FAIL reset_emit got a=%0d/%b/%b/%b b=%0d/%b/%b/%b want all 0",
                     cnt_a, c_a, dout_a, done_a, cnt_b, c_b, dout_b, done_b);
        end
        step;
        checks++;
        if ({dout_a, done_a, dout_b, done_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_emit_after got dout_a=%b done_a=%b dout_b=%b done_b=%b want 0",
                     dout_a, done_a, dout_b, done_b);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            accumulate($urandom_range(1, 40), 2'b00, 1'b1);
            emit($urandom_range(0, 20), $urandom_range(0, 4));
            restart;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_legacy_saturation;
        test_zero_count;
        test_freeze;
        test_abort;
        test_reset_emit;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
